elastic_async_operator: RTL and testbench

- Next-generation dataflow node for the arf graphs.
- Gathers one token from each of INPUT_SIZE upstream req/ack channels and computes a parametrised op.
- Pushes the result into an internal DEPTH-entry output FIFO, then delivers each result to OUTPUT_SIZE downstream consumers with independent per-branch handshakes.
- Decouples fetch from delivery, so upstream keeps filling while consumers stall, replacing the fixed single-slot operator plus separate reg nodes.

---
 rtl/elastic_async_operator_if.sv | 13 +
 rtl/elastic_async_operator.sv | 83 ++++++++
 tb/tb_elastic_async_operator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/elastic_async_operator_if.sv
// elastic_async_operator_if: upstream lanes, fork branches and status of one dataflow node
interface elastic_async_operator_if #(parameter int W = 32, NI = 2, NO = 1);
  logic [NI-1:0] req_l;
  logic [NI-1:0] ack_l;
  logic [W*NI-1:0] din;
  logic [NO-1:0] req_r;
  logic [NO-1:0] ack_r;
  logic [W-1:0] dout;
  logic [4:0] occupancy;
  logic [31:0] fired;
  modport master (output ack_l, din, req_r, input req_l, ack_r, dout, occupancy, fired);
  modport slave (input ack_l, din, req_r, output req_l, ack_r, dout, occupancy, fired);
endinterface

// File: rtl/elastic_async_operator.sv
// elastic_async_operator: joins INPUT_SIZE lanes, applies OP, queues results and forks each to OUTPUT_SIZE branches
module elastic_async_operator #(
  parameter int DATA_WIDTH = 32,
  parameter string OP = "add",
  parameter int IMMEDIATE = 0,
  parameter int INPUT_SIZE = 2,
  parameter int OUTPUT_SIZE = 1,
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst,
  elastic_async_operator_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam int NI = INPUT_SIZE;
  localparam int NO = OUTPUT_SIZE;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [NI-1:0] r_req_l, r_has, w_cap;
  logic [W-1:0] r_slot [NI];
  logic [W-1:0] r_mem [2**AW];
  logic [AW-1:0] r_rd, r_wr;
  logic [4:0] r_occ;
  logic [31:0] r_fired;
  logic [NO-1:0] r_done, r_ack_r, w_start;
  logic w_pop, w_fire;
  logic [W-1:0] w_sum, w_dif, w_prd, w_and, w_or, w_xor, w_res;
  assign w_cap = bus.ack_l & ~r_has;
  assign w_pop = &r_done;
  assign w_fire = &r_has && (r_occ < 5'(DEPTH) || w_pop);
  assign w_start = (r_occ != 0) ? bus.req_r & ~r_done & ~r_ack_r : '0;
  always_comb begin
    w_sum = r_slot[0];
    w_dif = r_slot[0];
    w_prd = r_slot[0];
    w_and = r_slot[0];
    w_or = r_slot[0];
    w_xor = r_slot[0];
    for (int i = 1; i < NI; i++) begin
      w_sum = w_sum + r_slot[i];
      w_dif = w_dif - r_slot[i];
      w_prd = w_prd * r_slot[i];
      w_and = w_and & r_slot[i];
      w_or = w_or | r_slot[i];
      w_xor = w_xor ^ r_slot[i];
    end
  end
  assign w_res = OP == "add" ? w_sum : OP == "sub" ? w_dif : OP == "mul" ? w_prd :
                 OP == "and" ? w_and : OP == "or" ? w_or : OP == "xor" ? w_xor :
                 OP == "addi" ? r_slot[0] + W'(IMMEDIATE) :
                 OP == "subi" ? r_slot[0] - W'(IMMEDIATE) :
                 OP == "muli" ? r_slot[0] * W'(IMMEDIATE) : r_slot[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_l <= '0;
      r_has <= '0;
      r_ack_r <= '0;
      r_done <= '0;
      r_occ <= '0;
      r_fired <= '0;
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      r_req_l <= ~r_has & ~bus.ack_l;
      r_has <= w_fire ? '0 : r_has | w_cap;
      r_ack_r <= w_start;
      r_done <= w_pop ? '0 : r_done | w_start;
      r_occ <= r_occ + 5'(w_fire) - 5'(w_pop);
      r_fired <= r_fired + 32'(w_fire);
      if (w_fire) r_wr <= r_wr == AW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == AW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
    end
  end
  // a full-FIFO push with a same-edge pop overwrites the departing head slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < NI; i++) if (w_cap[i]) r_slot[i] <= bus.din[W*i +: W];
    if (w_fire) r_mem[r_wr] <= w_res;
  end
  assign bus.req_l = r_req_l;
  assign bus.ack_r = r_ack_r;
  assign bus.dout = r_mem[r_rd];
  assign bus.occupancy = r_occ;
  assign bus.fired = r_fired;
endmodule

// File: tb/tb_elastic_async_operator.sv
// tb_elastic_async_operator: scoreboard run of a 3-lane sub / 2-branch node plus directed muli depth-1 checks
module tb_elastic_async_operator;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  elastic_async_operator_if #(.W(32), .NI(3), .NO(2)) a_if ();
  elastic_async_operator_if #(.W(32), .NI(1), .NO(1)) b_if ();
  elastic_async_operator #(.DATA_WIDTH(32), .OP("sub"), .INPUT_SIZE(3), .OUTPUT_SIZE(2), .DEPTH(4))
    u_a (.clk(clk), .rst(rst), .bus(a_if));
  elastic_async_operator #(.DATA_WIDTH(32), .OP("muli"), .IMMEDIATE(3), .INPUT_SIZE(1), .OUTPUT_SIZE(1), .DEPTH(1))
    u_b (.clk(clk), .rst(rst), .bus(b_if));
  int n_cmp = 0;
  int n_err = 0;
  int ntok = 0;
  logic [31:0] q0 [$], q1 [$], q2 [$], exq [$];
  logic [1:0] got = '0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // every branch must see each token exactly once, in order, before it leaves
  task automatic observe();
    for (int j = 0; j < 2; j++) if (a_if.ack_r[j]) begin
      chk("dup_ack", 32'(got[j]), 0);
      if (exq.size() == 0) chk("spurious_ack", 32'(a_if.ack_r), 0);
      else chk("head", a_if.dout, exq[0]);
      got[j] = 1'b1;
    end
    if (got == 2'b11) begin
      void'(exq.pop_front());
      got = '0;
    end
    chk("occ_bound", 32'(a_if.occupancy > 5'd4), 0);
  endtask
  task automatic step();
    @(negedge clk);
    observe();
    a_if.ack_l = '0;
  endtask
  task automatic push_a(logic [2:0] m, logic [31:0] v0, logic [31:0] v1, logic [31:0] v2);
    a_if.ack_l = m;
    a_if.din = {v2, v1, v0};
    if (m[0]) q0.push_back(v0);
    if (m[1]) q1.push_back(v1);
    if (m[2]) q2.push_back(v2);
    while (q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
      exq.push_back(q0.pop_front() - q1.pop_front() - q2.pop_front());
      ntok++;
    end
  endtask
  task automatic wait_req(logic [2:0] m);
    for (int t = 0; t < 20 && (a_if.req_l & m) != m; t++) step();
    chk("req_ready", 32'(a_if.req_l & m), 32'(m));
  endtask
  task automatic clear_model();
    q0.delete();
    q1.delete();
    q2.delete();
    exq.delete();
    got = '0;
    ntok = 0;
  endtask
  initial begin
    int n0, v;
    a_if.ack_l = '0;
    a_if.din = '0;
    a_if.req_r = '0;
    b_if.ack_l = '0;
    b_if.din = '0;
    b_if.req_r = '0;
    repeat (2) step();
    chk("rst_req_l", 32'(a_if.req_l), 0);
    chk("rst_ack_r", 32'(a_if.ack_r), 0);
    chk("rst_occ", 32'(a_if.occupancy), 0);
    chk("rst_fired", a_if.fired, 0);
    chk("rst_b_req_l", 32'(b_if.req_l), 0);
    rst = 0;
    a_if.req_r = 2'b11;
    wait_req(3'b111);
    push_a(3'b111, 10, 3, 4);
    step();
    chk("lat_k_ack", 32'(a_if.ack_r), 0);
    step();
    chk("lat_push_occ", 32'(a_if.occupancy), 1);
    chk("lat_fired", a_if.fired, 1);
    chk("lat_k1_ack", 32'(a_if.ack_r), 0);
    step();
    chk("lat_ack", 32'(a_if.ack_r), 3);
    chk("lat_dout", a_if.dout, 3);
    step();
    chk("lat_pop_ack", 32'(a_if.ack_r), 0);
    chk("lat_pop_occ", 32'(a_if.occupancy), 0);
    a_if.req_r = 2'b00;
    wait_req(3'b111);
    push_a(3'b111, 7, 0, 0);
    step();
    wait_req(3'b111);
    push_a(3'b111, 20, 5, 6);
    repeat (3) step();
    a_if.req_r = 2'b01;
    n0 = 0;
    repeat (10) begin
      step();
      n0 += int'(a_if.ack_r[0]);
    end
    chk("stall_acks0", n0, 1);
    chk("stall_occ", 32'(a_if.occupancy), 2);
    chk("stall_head", a_if.dout, 7);
    a_if.req_r = 2'b11;
    step();
    chk("stall_ack1", 32'(a_if.ack_r), 2);
    chk("stall_ack1_dout", a_if.dout, 7);
    step();
    chk("next_head", a_if.dout, 9);
    chk("next_occ", 32'(a_if.occupancy), 1);
    chk("next_ack", 32'(a_if.ack_r), 0);
    repeat (4) step();
    a_if.req_r = 2'b00;
    v = 1;
    repeat (40) begin
      if (a_if.req_l == 3'b111 && v < 100) begin
        push_a(3'b111, v, 0, 0);
        v++;
      end
      step();
    end
    chk("sat_occ", 32'(a_if.occupancy), 4);
    chk("sat_req_l", 32'(a_if.req_l), 0);
    chk("sat_caps", v, 6);
    chk("sat_fired", a_if.fired, ntok - 1);
    a_if.req_r = 2'b11;
    repeat (20) step();
    chk("sat_drained", 32'(a_if.occupancy), 0);
    chk("sat_model_empty", exq.size(), 0);
    a_if.req_r = 2'b00;
    repeat (3) begin
      wait_req(3'b111);
      push_a(3'b111, $urandom, $urandom, $urandom);
      step();
    end
    wait_req(3'b111);
    push_a(3'b001, 99, 0, 0);
    repeat (2) step();
    chk("pre_rst_occ", 32'(a_if.occupancy), 3);
    rst = 1;
    a_if.req_r = 2'b11;
    step();
    rst = 0;
    clear_model();
    chk("mid_rst_req_l", 32'(a_if.req_l), 0);
    chk("mid_rst_ack_r", 32'(a_if.ack_r), 0);
    chk("mid_rst_occ", 32'(a_if.occupancy), 0);
    chk("mid_rst_fired", a_if.fired, 0);
    n0 = 0;
    repeat (6) begin
      step();
      n0 += int'(|a_if.ack_r);
    end
    chk("no_stale_ack", n0, 0);
    wait_req(3'b111);
    push_a(3'b111, 50, 8, 2);
    repeat (5) step();
    chk("fresh_done", exq.size(), 0);
    repeat (3000) begin
      a_if.req_r = 2'($urandom);
      push_a(a_if.req_l & 3'($urandom), $urandom, $urandom, $urandom);
      step();
    end
    a_if.req_r = 2'b11;
    repeat (40) step();
    chk("drain_model", exq.size(), 0);
    chk("drain_occ", 32'(a_if.occupancy), 0);
    chk("fired_total", a_if.fired, ntok);
    for (int t = 0; t < 20 && !b_if.req_l[0]; t++) step();
    chk("b_req", 32'(b_if.req_l), 1);
    b_if.ack_l = 1'b1;
    b_if.din = 32'h6000_0000;
    step();
    b_if.ack_l = 1'b0;
    step();
    chk("muli_dout", b_if.dout, 32'h2000_0000);
    chk("muli_occ", 32'(b_if.occupancy), 1);
    for (int t = 0; t < 20 && !b_if.req_l[0]; t++) step();
    b_if.ack_l = 1'b1;
    b_if.din = 32'd2;
    step();
    b_if.ack_l = 1'b0;
    repeat (2) step();
    chk("held_fired", b_if.fired, 1);
    chk("held_occ", 32'(b_if.occupancy), 1);
    chk("held_req_l", 32'(b_if.req_l), 0);
    b_if.req_r = 1'b1;
    step();
    chk("b_ack", 32'(b_if.ack_r), 1);
    chk("b_ack_dout", b_if.dout, 32'h2000_0000);
    step();
    chk("swap_occ", 32'(b_if.occupancy), 1);
    chk("swap_dout", b_if.dout, 6);
    chk("swap_fired", b_if.fired, 2);
    chk("swap_ack", 32'(b_if.ack_r), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
